// File: rtl/dvp_capture.sv
// DVP receiver: registers the parallel camera bus, packs byte pairs into
// RGB565 pixels, and reports frame/line markers plus measured geometry.
module dvp_capture #(
  parameter bit VS_ACTIVE_HIGH = 1'b1,
  parameter bit HS_ACTIVE_HIGH = 1'b1,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int CNT_W          = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic [7:0]       i_data,
  output logic [15:0]      o_pix_data,
  output logic             o_pix_valid,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_eof,
  output logic [CNT_W-1:0] o_line_width,
  output logic [CNT_W-1:0] o_frame_width,
  output logic [CNT_W-1:0] o_frame_height,
  output logic             o_err,
  output logic [7:0]       o_err_cnt,
  output logic             o_busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_GAP = 2'd1;
  localparam logic [1:0] S_ARMED    = 2'd2;
  localparam logic [1:0] S_CAPTURE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]       state, state_nxt;
  logic             vsync_r, hsync_r;
  logic [7:0]       data_r;
  logic             vs, hs, hs_q;
  logic             vs_d1, vs_d2, hs_q_d1, hs_q_d2;
  logic             capturing, hs_q_rise, vs_rise, line_end, frame_end;
  logic             phase, phase_eff, sof_pending;
  logic [7:0]       byte0;
  logic [CNT_W-1:0] pix_cnt, line_cnt;

  assign vs        = VS_ACTIVE_HIGH ? vsync_r : ~vsync_r;
  assign hs        = HS_ACTIVE_HIGH ? hsync_r : ~hsync_r;
  assign hs_q      = hs & vs;
  assign capturing = (state == S_CAPTURE);
  assign o_busy    = capturing;

  // Rising edges act on the live strobe; falling edges are taken one stage
  // later so line and frame ends are reported from the delayed pair.
  assign hs_q_rise = hs_q & ~hs_q_d1;
  assign vs_rise   = vs & ~vs_d1;
  assign line_end  = capturing & hs_q_d2 & ~hs_q_d1;
  assign frame_end = capturing & vs_d2 & ~vs_d1;
  assign phase_eff = hs_q_rise ? 1'b0 : phase;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (i_en) state_nxt = S_WAIT_GAP;
      S_WAIT_GAP: if (!i_en) state_nxt = S_IDLE;
                  else if (!vs) state_nxt = S_ARMED;
      S_ARMED:    if (!i_en) state_nxt = S_IDLE;
                  else if (vs_rise) state_nxt = S_CAPTURE;
      S_CAPTURE:  if (frame_end) state_nxt = i_en ? S_ARMED : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every register below uses non-blocking assignment so each edge
  // sees the previous cycle's values, which the edge detectors depend on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      vsync_r        <= 1'b0;
      hsync_r        <= 1'b0;
      data_r         <= '0;
      vs_d1          <= 1'b0;
      vs_d2          <= 1'b0;
      hs_q_d1        <= 1'b0;
      hs_q_d2        <= 1'b0;
      phase          <= 1'b0;
      sof_pending    <= 1'b0;
      byte0          <= '0;
      pix_cnt        <= '0;
      line_cnt       <= '0;
      o_pix_data     <= '0;
      o_pix_valid    <= 1'b0;
      o_sof          <= 1'b0;
      o_eol          <= 1'b0;
      o_eof          <= 1'b0;
      o_line_width   <= '0;
      o_frame_width  <= '0;
      o_frame_height <= '0;
      o_err          <= 1'b0;
      o_err_cnt      <= '0;
    end else begin
      vsync_r     <= i_vsync;
      hsync_r     <= i_hsync;
      data_r      <= i_data;
      vs_d1       <= vs;
      vs_d2       <= vs_d1;
      hs_q_d1     <= hs_q;
      hs_q_d2     <= hs_q_d1;
      state       <= state_nxt;
      o_pix_valid <= 1'b0;
      o_sof       <= 1'b0;
      o_eol       <= 1'b0;
      o_eof       <= 1'b0;
      o_err       <= 1'b0;

      if (!capturing) begin
        phase       <= 1'b0;
        pix_cnt     <= '0;
        line_cnt    <= '0;
        sof_pending <= 1'b1;
      end else begin
        if (line_end) begin
          o_eol        <= 1'b1;
          o_line_width <= pix_cnt;
          pix_cnt      <= '0;
          line_cnt     <= line_cnt + CNT_ONE;
          phase        <= 1'b0;
          if (phase) begin
            o_err <= 1'b1;
            if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
          end
        end

        // A new line may start on the same edge an old one is retired, so
        // the packing update is written after the line-end clear.
        if (hs_q) begin
          if (!phase_eff) begin
            byte0 <= data_r;
            phase <= 1'b1;
          end else begin
            phase       <= 1'b0;
            o_pix_valid <= 1'b1;
            o_pix_data  <= MSB_FIRST ? {byte0, data_r} : {data_r, byte0};
            pix_cnt     <= pix_cnt + CNT_ONE;
            o_sof       <= sof_pending;
            sof_pending <= 1'b0;
          end
        end

        if (frame_end) begin
          o_eof          <= 1'b1;
          o_frame_width  <= line_end ? pix_cnt : o_line_width;
          o_frame_height <= line_end ? line_cnt + CNT_ONE : line_cnt;
          line_cnt       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture: a default-polarity instance plus an
// inverted-polarity, LSB-first instance fed the logically identical bus.
module tb_dvp_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic        i_vsync;
  logic        i_hsync;
  logic [7:0]  i_data;

  logic [15:0] o_pix_data;
  logic        o_pix_valid, o_sof, o_eol, o_eof, o_err, o_busy;
  logic [11:0] o_line_width, o_frame_width, o_frame_height;
  logic [7:0]  o_err_cnt;

  logic [15:0] b_pix_data;
  logic        b_pix_valid, b_sof, b_eol, b_eof, b_err, b_busy;
  logic [11:0] b_line_width, b_frame_width, b_frame_height;
  logic [7:0]  b_err_cnt;

  always #5 clk = ~clk;

  dvp_capture dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .i_vsync(i_vsync), .i_hsync(i_hsync), .i_data(i_data),
    .o_pix_data(o_pix_data), .o_pix_valid(o_pix_valid), .o_sof(o_sof),
    .o_eol(o_eol), .o_eof(o_eof), .o_line_width(o_line_width),
    .o_frame_width(o_frame_width), .o_frame_height(o_frame_height),
    .o_err(o_err), .o_err_cnt(o_err_cnt), .o_busy(o_busy)
  );

  dvp_capture #(
    .VS_ACTIVE_HIGH(1'b0), .HS_ACTIVE_HIGH(1'b0), .MSB_FIRST(1'b0), .CNT_W(12)
  ) dut_inv (
    .clk(clk), .rst(rst), .i_en(i_en),
    .i_vsync(~i_vsync), .i_hsync(~i_hsync), .i_data(i_data),
    .o_pix_data(b_pix_data), .o_pix_valid(b_pix_valid), .o_sof(b_sof),
    .o_eol(b_eol), .o_eof(b_eof), .o_line_width(b_line_width),
    .o_frame_width(b_frame_width), .o_frame_height(b_frame_height),
    .o_err(b_err), .o_err_cnt(b_err_cnt), .o_busy(b_busy)
  );

  // Output monitor, sampled on the falling edge.
  int          cyc = 0;
  logic [15:0] pix_q[$];
  logic [15:0] pix2_q[$];
  int sof_cnt = 0, eol_cnt = 0, eof_cnt = 0, err_ev = 0;
  int last_pix_cyc = 0, eol_cyc = 0, eof_cyc = 0, err_cyc = 0;
  int eol_gap = 0, sof_idx = -1;
  logic [11:0] last_lw = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_pix_valid) begin
      pix_q.push_back(o_pix_data);
      last_pix_cyc <= cyc;
    end
    if (b_pix_valid) pix2_q.push_back(b_pix_data);
    if (o_sof) begin
      sof_cnt <= sof_cnt + 1;
      sof_idx <= pix_q.size() - 1;
    end
    if (o_eol) begin
      eol_cnt <= eol_cnt + 1;
      eol_cyc <= cyc;
      eol_gap <= cyc - last_pix_cyc;
      last_lw <= o_line_width;
    end
    if (o_eof) begin
      eof_cnt <= eof_cnt + 1;
      eof_cyc <= cyc;
    end
    if (o_err) begin
      err_ev  <= err_ev + 1;
      err_cyc <= cyc;
    end
  end

  int checks = 0;
  int errors = 0;
  int p0, q0, s0, l0, f0, e0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    p0 = pix_q.size();
    q0 = pix2_q.size();
    s0 = sof_cnt;
    l0 = eol_cnt;
    f0 = eof_cnt;
    e0 = err_ev;
  endtask

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(posedge clk);
    #1;
    i_vsync = v;
    i_hsync = h;
    i_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, base + 8'(i));
    repeat (2) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic frame(input int nlines, input int nbytes, input logic [7:0] base);
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < nlines; l++) line(nbytes, base);
    idle(6);
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0; i_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({o_pix_data, o_pix_valid, o_sof, o_eol, o_eof, o_err, o_busy}), 64'd0);
    check("reset_counts", 64'({o_line_width, o_frame_width, o_frame_height, o_err_cnt}), 64'd0);
    check("reset_inv_busy", 64'(b_busy), 64'd0);
    rst = 1'b0;

    // Basic frame: 3 lines of 0x00..0x07.
    i_en = 1'b1;
    idle(4);
    snap();
    frame(3, 8, 8'h00);
    check("basic_pix_count", 64'(pix_q.size() - p0), 64'd12);
    check("basic_pix0", 64'(pix_q[p0]), 64'h0001);
    check("basic_pix1", 64'(pix_q[p0 + 1]), 64'h0203);
    check("basic_pix3", 64'(pix_q[p0 + 3]), 64'h0607);
    check("basic_pix11", 64'(pix_q[p0 + 11]), 64'h0607);
    check("basic_sof_count", 64'(sof_cnt - s0), 64'd1);
    check("basic_sof_first_pix", 64'(sof_idx), 64'(p0));
    check("basic_eol_count", 64'(eol_cnt - l0), 64'd3);
    check("basic_line_width", 64'(last_lw), 64'd4);
    check("basic_eol_latency", 64'(eol_gap), 64'd2);
    check("basic_eof_count", 64'(eof_cnt - f0), 64'd1);
    check("basic_frame_width", 64'(o_frame_width), 64'd4);
    check("basic_frame_height", 64'(o_frame_height), 64'd3);
    check("basic_no_err", 64'(o_err_cnt), 64'd0);
    check("inv_lsb_first_pix0", 64'(pix2_q[q0]), 64'h0100);

    // Enable raised partway through line 2: that frame is skipped.
    i_en = 1'b0;
    idle(2);
    snap();
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    line(8, 8'h40);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) i_en = 1'b1;
      drive(1'b1, 1'b1, 8'h48 + 8'(i));
    end
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    line(8, 8'h50);
    idle(6);
    check("midfen_skip_pix", 64'(pix_q.size() - p0), 64'd0);
    check("midfen_skip_eof", 64'(eof_cnt - f0), 64'd0);
    snap();
    frame(3, 8, 8'h10);
    check("midfen_next_pix", 64'(pix_q.size() - p0), 64'd12);
    check("midfen_next_pix0", 64'(pix_q[p0]), 64'h1011);
    check("midfen_next_sof", 64'(sof_cnt - s0), 64'd1);
    check("midfen_next_eof", 64'(eof_cnt - f0), 64'd1);
    check("midfen_next_height", 64'(o_frame_height), 64'd3);

    // Odd byte count: 7 bytes -> 3 pixels and one error.
    snap();
    frame(1, 7, 8'h20);
    check("odd_pix_count", 64'(pix_q.size() - p0), 64'd3);
    check("odd_pix2", 64'(pix_q[p0 + 2]), 64'h2425);
    check("odd_err_pulses", 64'(err_ev - e0), 64'd1);
    check("odd_err_cnt", 64'(o_err_cnt), 64'd1);
    check("odd_line_width", 64'(last_lw), 64'd3);
    check("odd_err_with_eol", 64'(err_cyc), 64'(eol_cyc));
    check("odd_frame_width", 64'(o_frame_width), 64'd3);

    // Byte order and polarity: 0xAA then 0x55.
    snap();
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'hAA);
    drive(1'b1, 1'b1, 8'h55);
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    idle(6);
    check("order_msb_first", 64'(pix_q[p0]), 64'hAA55);
    check("order_inv_lsb_first", 64'(pix2_q[q0]), 64'h55AA);

    // Enable dropped mid-frame: frame completes, then the next is ignored.
    snap();
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    line(4, 8'h50);
    i_en = 1'b0;
    line(4, 8'h54);
    idle(6);
    check("dis_eof", 64'(eof_cnt - f0), 64'd1);
    check("dis_height", 64'(o_frame_height), 64'd2);
    check("dis_pix_count", 64'(pix_q.size() - p0), 64'd4);
    check("dis_busy_low", 64'(o_busy), 64'd0);
    snap();
    frame(2, 4, 8'h60);
    check("dis_ignored_pix", 64'(pix_q.size() - p0), 64'd0);
    check("dis_ignored_eof", 64'(eof_cnt - f0), 64'd0);

    // Reset asserted mid-line.
    i_en = 1'b1;
    idle(4);
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'h70 + 8'(i));
    check("rst_pre_valid", 64'(o_pix_valid), 64'd1);
    check("rst_pre_busy", 64'(o_busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_flags", 64'({o_pix_data, o_pix_valid, o_sof, o_eol, o_eof, o_err, o_busy}), 64'd0);
    check("rst_mid_counts", 64'({o_line_width, o_frame_width, o_frame_height, o_err_cnt}), 64'd0);
    drive(1'b1, 1'b1, 8'h74);
    drive(1'b1, 1'b1, 8'h75);
    rst = 1'b0;
    snap();
    drive(1'b1, 1'b1, 8'h76);
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    idle(6);
    check("rst_no_resume_pix", 64'(pix_q.size() - p0), 64'd0);
    check("rst_no_resume_eof", 64'(eof_cnt - f0), 64'd0);

    // 300 one-byte lines: error counter saturates.
    snap();
    frame(300, 1, 8'h80);
    check("sat_err_cnt", 64'(o_err_cnt), 64'd255);
    check("sat_err_pulses", 64'(err_ev - e0), 64'd300);
    check("sat_height", 64'(o_frame_height), 64'd300);
    check("sat_frame_width", 64'(o_frame_width), 64'd0);

    // vsync and hsync fall together.
    snap();
    repeat (2) drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'h90 + 8'(i));
    idle(6);
    check("sim_eol", 64'(eol_cnt - l0), 64'd1);
    check("sim_eof", 64'(eof_cnt - f0), 64'd1);
    check("sim_same_cycle", 64'(eol_cyc), 64'(eof_cyc));
    check("sim_line_width", 64'(o_line_width), 64'd2);
    check("sim_frame_width", 64'(o_frame_width), 64'd2);
    check("sim_height", 64'(o_frame_height), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
